// File: rtl/idu_exu_stage_pkg.sv
// Shared types and constants for the IDU->EXU pipeline register.
package idu_exu_stage_pkg;

  localparam int unsigned DecInfoWidth = 32;

  localparam int unsigned XLen      = 32;
  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned HoldCntW  = 8;
  localparam logic [XLen-1:0] NopInst = 32'h00000001;

  typedef struct packed {
    logic [XLen-1:0]         inst;
    logic [DecInfoWidth-1:0] dec_info;
    logic [XLen-1:0]         imm;
    logic [XLen-1:0]         pc;
    logic [RegAddrW-1:0]     rd;
    logic                    rd_we;
    logic [XLen-1:0]         rs1_data;
    logic [XLen-1:0]         rs2_data;
  } idu_exu_bundle_t;

  // Bundle presented to EXU when no instruction is in the stage.
  function automatic idu_exu_bundle_t bubble_bundle();
    idu_exu_bundle_t b;
    b      = '0;
    b.inst = NopInst;
    return b;
  endfunction

endpackage

// File: rtl/idu_exu_stage_if.sv
// Signal bundle between IDU/GPR/EXU and the idu_exu_stage pipeline register.
interface idu_exu_stage_if;
  import idu_exu_stage_pkg::*;

  logic                    hold_i;
  logic                    flush_i;
  logic                    inst_valid_i;
  logic [XLen-1:0]         inst_i;
  logic [DecInfoWidth-1:0] dec_info_bus_i;
  logic [XLen-1:0]         dec_imm_i;
  logic [XLen-1:0]         dec_pc_i;
  logic [RegAddrW-1:0]     rd_waddr_i;
  logic                    rd_we_i;
  logic [RegAddrW-1:0]     rs1_raddr_i;
  logic [RegAddrW-1:0]     rs2_raddr_i;
  logic [XLen-1:0]         reg1_rdata_i;
  logic [XLen-1:0]         reg2_rdata_i;
  logic                    wb_we_i;
  logic [RegAddrW-1:0]     wb_waddr_i;
  logic [XLen-1:0]         wb_wdata_i;

  logic                    inst_valid_o;
  logic [XLen-1:0]         inst_o;
  logic [DecInfoWidth-1:0] dec_info_bus_o;
  logic [XLen-1:0]         dec_imm_o;
  logic [XLen-1:0]         dec_pc_o;
  logic [RegAddrW-1:0]     rd_waddr_o;
  logic                    rd_we_o;
  logic [XLen-1:0]         reg1_rdata_o;
  logic [XLen-1:0]         reg2_rdata_o;
  logic [HoldCntW-1:0]     hold_cycles_o;

  modport master (
    output hold_i, flush_i, inst_valid_i, inst_i, dec_info_bus_i, dec_imm_i,
           dec_pc_i, rd_waddr_i, rd_we_i, rs1_raddr_i, rs2_raddr_i,
           reg1_rdata_i, reg2_rdata_i, wb_we_i, wb_waddr_i, wb_wdata_i,
    input  inst_valid_o, inst_o, dec_info_bus_o, dec_imm_o, dec_pc_o,
           rd_waddr_o, rd_we_o, reg1_rdata_o, reg2_rdata_o, hold_cycles_o
  );

  modport slave (
    input  hold_i, flush_i, inst_valid_i, inst_i, dec_info_bus_i, dec_imm_i,
           dec_pc_i, rd_waddr_i, rd_we_i, rs1_raddr_i, rs2_raddr_i,
           reg1_rdata_i, reg2_rdata_i, wb_we_i, wb_waddr_i, wb_wdata_i,
    output inst_valid_o, inst_o, dec_info_bus_o, dec_imm_o, dec_pc_o,
           rd_waddr_o, rd_we_o, reg1_rdata_o, reg2_rdata_o, hold_cycles_o
  );

endinterface

// File: rtl/idu_exu_bypass.sv
// Write-back forwarding for one operand: picks EXU write data when it targets
// the operand's source register (x0 never forwards).
module idu_exu_bypass
  import idu_exu_stage_pkg::*;
(
  input  logic                wb_we_i,
  input  logic [RegAddrW-1:0] wb_waddr_i,
  input  logic [XLen-1:0]     wb_wdata_i,
  input  logic [RegAddrW-1:0] raddr_i,
  input  logic [XLen-1:0]     rdata_i,
  output logic [XLen-1:0]     rdata_c
);

  logic hit_c;

  always_comb begin
    hit_c   = wb_we_i && (wb_waddr_i != '0) && (wb_waddr_i == raddr_i);
    rdata_c = hit_c ? wb_wdata_i : rdata_i;
  end

endmodule

// File: rtl/idu_exu_stage.sv
// IDU->EXU pipeline register with hold, flush and bubble insertion.
// Optional macro IDU_EXU_WB_BYPASS_EN forwards EXU write-back into operands.
module idu_exu_stage
  import idu_exu_stage_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  idu_exu_stage_if.slave bus
);

  logic                valid_q, valid_d;
  idu_exu_bundle_t     bundle_q, bundle_d;
  logic [RegAddrW-1:0] rs1_q, rs1_d;
  logic [RegAddrW-1:0] rs2_q, rs2_d;
  logic [HoldCntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [XLen-1:0]     rs1_data_c, rs2_data_c;

`ifdef IDU_EXU_WB_BYPASS_EN
  // While held, forwarding compares against the stored indices and data.
  logic [RegAddrW-1:0] byp_rs1_addr_c, byp_rs2_addr_c;
  logic [XLen-1:0]     byp_rs1_data_c, byp_rs2_data_c;

  always_comb begin
    byp_rs1_addr_c = bus.hold_i ? rs1_q : bus.rs1_raddr_i;
    byp_rs2_addr_c = bus.hold_i ? rs2_q : bus.rs2_raddr_i;
    byp_rs1_data_c = bus.hold_i ? bundle_q.rs1_data : bus.reg1_rdata_i;
    byp_rs2_data_c = bus.hold_i ? bundle_q.rs2_data : bus.reg2_rdata_i;
  end

  idu_exu_bypass u_byp_rs1 (
    .wb_we_i    (bus.wb_we_i),
    .wb_waddr_i (bus.wb_waddr_i),
    .wb_wdata_i (bus.wb_wdata_i),
    .raddr_i    (byp_rs1_addr_c),
    .rdata_i    (byp_rs1_data_c),
    .rdata_c    (rs1_data_c)
  );

  idu_exu_bypass u_byp_rs2 (
    .wb_we_i    (bus.wb_we_i),
    .wb_waddr_i (bus.wb_waddr_i),
    .wb_wdata_i (bus.wb_wdata_i),
    .raddr_i    (byp_rs2_addr_c),
    .rdata_i    (byp_rs2_data_c),
    .rdata_c    (rs2_data_c)
  );
`else
  logic unused_wb_c;

  always_comb begin
    rs1_data_c  = bus.hold_i ? bundle_q.rs1_data : bus.reg1_rdata_i;
    rs2_data_c  = bus.hold_i ? bundle_q.rs2_data : bus.reg2_rdata_i;
    unused_wb_c = ^{bus.wb_we_i, bus.wb_waddr_i, bus.wb_wdata_i, rs1_q, rs2_q};
  end
`endif

  // Next-state: flush beats hold beats load.
  always_comb begin
    valid_d    = valid_q;
    bundle_d   = bundle_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    hold_cnt_d = hold_cnt_q;

    if (bus.flush_i) begin
      valid_d    = 1'b0;
      bundle_d   = bubble_bundle();
      rs1_d      = '0;
      rs2_d      = '0;
      hold_cnt_d = '0;
    end else if (bus.hold_i) begin
      bundle_d.rs1_data = rs1_data_c;
      bundle_d.rs2_data = rs2_data_c;
      hold_cnt_d        = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HoldCntW'(1);
    end else begin
      hold_cnt_d = '0;
      if (bus.inst_valid_i) begin
        valid_d           = 1'b1;
        bundle_d.inst     = bus.inst_i;
        bundle_d.dec_info = bus.dec_info_bus_i;
        bundle_d.imm      = bus.dec_imm_i;
        bundle_d.pc       = bus.dec_pc_i;
        bundle_d.rd       = bus.rd_waddr_i;
        bundle_d.rd_we    = bus.rd_we_i;
        bundle_d.rs1_data = rs1_data_c;
        bundle_d.rs2_data = rs2_data_c;
        rs1_d             = bus.rs1_raddr_i;
        rs2_d             = bus.rs2_raddr_i;
      end else begin
        valid_d  = 1'b0;
        bundle_d = bubble_bundle();
        rs1_d    = '0;
        rs2_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      bundle_q   <= bubble_bundle();
      rs1_q      <= '0;
      rs2_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      bundle_q   <= bundle_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.inst_valid_o   = valid_q;
  assign bus.inst_o         = bundle_q.inst;
  assign bus.dec_info_bus_o = bundle_q.dec_info;
  assign bus.dec_imm_o      = bundle_q.imm;
  assign bus.dec_pc_o       = bundle_q.pc;
  assign bus.rd_waddr_o     = bundle_q.rd;
  assign bus.rd_we_o        = bundle_q.rd_we;
  assign bus.reg1_rdata_o   = bundle_q.rs1_data;
  assign bus.reg2_rdata_o   = bundle_q.rs2_data;
  assign bus.hold_cycles_o  = hold_cnt_q;

endmodule

// File: tb/tb_idu_exu_stage.sv
// Bench for idu_exu_stage: directed table, hand sequences and random stimulus
// against a behavioural model of the stage.
module tb_idu_exu_stage;
  import idu_exu_stage_pkg::*;

`ifdef IDU_EXU_WB_BYPASS_EN
  localparam bit BypOn = 1'b1;
`else
  localparam bit BypOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  idu_exu_stage_if bus ();

  idu_exu_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_inst, m_imm, m_pc, m_r1, m_r2;
  logic [63:0] m_dec;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic        m_we;
  int          m_cnt;

  typedef struct {
    logic        hold, flush, valid, we;
    logic [31:0] inst, pc;
    logic        e_valid, e_we;
    logic [31:0] e_inst, e_pc;
    int          e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_inst = 32'h00000001; m_dec = '0; m_imm = '0; m_pc = '0;
    m_rd = '0; m_we = 1'b0; m_r1 = '0; m_r2 = '0; m_rs1 = '0; m_rs2 = '0;
  endtask

  function automatic bit fwd(input logic [4:0] idx);
    return BypOn && bus.wb_we_i && (bus.wb_waddr_i != 5'd0) && (bus.wb_waddr_i == idx);
  endfunction

  task automatic model_step();
    if (bus.flush_i) begin
      model_bubble();
      m_cnt = 0;
    end else if (bus.hold_i) begin
      if (fwd(m_rs1)) m_r1 = bus.wb_wdata_i;
      if (fwd(m_rs2)) m_r2 = bus.wb_wdata_i;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end else begin
      m_cnt = 0;
      if (bus.inst_valid_i) begin
        m_valid = 1'b1; m_inst = bus.inst_i; m_dec = 64'(bus.dec_info_bus_i);
        m_imm = bus.dec_imm_i; m_pc = bus.dec_pc_i; m_rd = bus.rd_waddr_i;
        m_we = bus.rd_we_i; m_rs1 = bus.rs1_raddr_i; m_rs2 = bus.rs2_raddr_i;
        m_r1 = fwd(bus.rs1_raddr_i) ? bus.wb_wdata_i : bus.reg1_rdata_i;
        m_r2 = fwd(bus.rs2_raddr_i) ? bus.wb_wdata_i : bus.reg2_rdata_i;
      end else begin
        model_bubble();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 64'(bus.inst_valid_o), 64'(m_valid));
    chk({tag, ".inst"},  64'(bus.inst_o), 64'(m_inst));
    chk({tag, ".dec"},   64'(bus.dec_info_bus_o), m_dec);
    chk({tag, ".imm"},   64'(bus.dec_imm_o), 64'(m_imm));
    chk({tag, ".pc"},    64'(bus.dec_pc_o), 64'(m_pc));
    chk({tag, ".rd"},    64'(bus.rd_waddr_o), 64'(m_rd));
    chk({tag, ".rd_we"}, 64'(bus.rd_we_o), 64'(m_we));
    chk({tag, ".r1"},    64'(bus.reg1_rdata_o), 64'(m_r1));
    chk({tag, ".r2"},    64'(bus.reg2_rdata_o), 64'(m_r2));
    chk({tag, ".hcnt"},  64'(bus.hold_cycles_o), 64'(m_cnt));
  endtask

  // One clock: model consumes current inputs, DUT output sampled 1ns after the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive_random();
    bus.flush_i        = ($urandom_range(0, 9) == 0);
    bus.hold_i         = ($urandom_range(0, 9) < 3);
    bus.inst_valid_i   = ($urandom_range(0, 9) < 7);
    bus.inst_i         = $urandom;
    bus.dec_info_bus_i = DecInfoWidth'({$urandom, $urandom});
    bus.dec_imm_i      = $urandom;
    bus.dec_pc_i       = $urandom;
    bus.rd_waddr_i     = 5'($urandom);
    bus.rd_we_i        = 1'($urandom);
    bus.rs1_raddr_i    = 5'($urandom_range(0, 7));
    bus.rs2_raddr_i    = 5'($urandom_range(0, 7));
    bus.reg1_rdata_i   = $urandom;
    bus.reg2_rdata_i   = $urandom;
    bus.wb_we_i        = 1'($urandom);
    bus.wb_waddr_i     = 5'($urandom_range(0, 7));
    bus.wb_wdata_i     = $urandom;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00a00093, 32'h100, 1'b1, 1'b1, 32'h00a00093, 32'h100, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h104, 1'b1, 1'b1, 32'h00a00093, 32'h100, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h22222222, 32'h108, 1'b1, 1'b1, 32'h00a00093, 32'h100, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h33333333, 32'h10c, 1'b1, 1'b1, 32'h00a00093, 32'h100, 3};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00200113, 32'h110, 1'b1, 1'b1, 32'h00200113, 32'h110, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h44444444, 32'h114, 1'b0, 1'b0, 32'h00000001, 32'h0,   0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 32'h118, 1'b0, 1'b0, 32'h00000001, 32'h0,   0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00300193, 32'h11c, 1'b1, 1'b0, 32'h00300193, 32'h11c, 0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h66666666, 32'h120, 1'b1, 1'b0, 32'h00300193, 32'h11c, 1};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h77777777, 32'h124, 1'b0, 1'b0, 32'h00000001, 32'h0,   0};

    // Reset with active inputs, released between edges
    drive_random();
    bus.flush_i = 1'b0; bus.hold_i = 1'b0; bus.inst_valid_i = 1'b1;
    #2;
    model_bubble();
    m_cnt = 0;
    chk("rst_async.valid", 64'(bus.inst_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.valid", 64'(bus.inst_valid_o), 64'd0);
    chk("rst.inst",  64'(bus.inst_o), 64'h00000001);
    chk("rst.dec",   64'(bus.dec_info_bus_o), 64'd0);
    compare_all("rst");

    // Directed table
    bus.wb_we_i = 1'b0;
    bus.dec_info_bus_i = DecInfoWidth'(32'hA5);
    for (int i = 0; i < 10; i++) begin
      bus.hold_i = vecs[i].hold; bus.flush_i = vecs[i].flush;
      bus.inst_valid_i = vecs[i].valid; bus.rd_we_i = vecs[i].we;
      bus.inst_i = vecs[i].inst; bus.dec_pc_i = vecs[i].pc;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_valid", i), 64'(bus.inst_valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.t_inst", i),  64'(bus.inst_o), 64'(vecs[i].e_inst));
      chk($sformatf("vec%0d.t_pc", i),    64'(bus.dec_pc_o), 64'(vecs[i].e_pc));
      chk($sformatf("vec%0d.t_we", i),    64'(bus.rd_we_o), 64'(vecs[i].e_we));
      chk($sformatf("vec%0d.t_hcnt", i),  64'(bus.hold_cycles_o), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.t_dec", i),   64'(bus.dec_info_bus_o),
          vecs[i].e_valid ? 64'(DecInfoWidth'(32'hA5)) : 64'd0);
    end

    // Operand forwarding: load rs1=5, then hold with write-backs to x5 and x0
    bus.flush_i = 1'b0; bus.hold_i = 1'b0; bus.inst_valid_i = 1'b1;
    bus.rs1_raddr_i = 5'd5; bus.rs2_raddr_i = 5'd7;
    bus.reg1_rdata_i = 32'h11111111; bus.reg2_rdata_i = 32'h22222222;
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd7; bus.wb_wdata_i = 32'h0BADF00D;
    step("byp_load");
    chk("byp_load.r2", 64'(bus.reg2_rdata_o), BypOn ? 64'h0BADF00D : 64'h22222222);
    bus.hold_i = 1'b1; bus.wb_waddr_i = 5'd5; bus.wb_wdata_i = 32'hDEADBEEF;
    bus.reg1_rdata_i = 32'h33333333;
    step("byp_hold");
    chk("byp_hold.r1", 64'(bus.reg1_rdata_o), BypOn ? 64'hDEADBEEF : 64'h11111111);
    bus.wb_waddr_i = 5'd0; bus.wb_wdata_i = 32'hCAFEF00D;
    step("byp_x0");
    chk("byp_x0.r1", 64'(bus.reg1_rdata_o), BypOn ? 64'hDEADBEEF : 64'h11111111);

    // Asynchronous reset in the middle of a hold
    bus.wb_we_i = 1'b0;
    step("pre_rst_hold");
    rst_n = 1'b0;
    #1;
    model_bubble();
    m_cnt = 0;
    chk("midrst.valid", 64'(bus.inst_valid_o), 64'd0);
    chk("midrst.hcnt",  64'(bus.hold_cycles_o), 64'd0);
    compare_all("midrst");
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step("rand");
    end

    // Hold counter saturation
    bus.flush_i = 1'b0; bus.hold_i = 1'b0; bus.inst_valid_i = 1'b1; bus.wb_we_i = 1'b0;
    step("sat_load");
    bus.hold_i = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step("sat");
      if (i == 254) chk("sat.254", 64'(bus.hold_cycles_o), 64'd254);
      if (i >= 255) chk("sat.ff", 64'(bus.hold_cycles_o), 64'hFF);
    end
    bus.hold_i = 1'b0; bus.flush_i = 1'b1;
    step("sat_release_flush");
    chk("sat_release_flush.valid", 64'(bus.inst_valid_o), 64'd0);
    chk("sat_release_flush.hcnt", 64'(bus.hold_cycles_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idu_exu_stage.md
Name: idu_exu_stage

Overview:
- Pipeline register between the decoder (IDU) and the execute unit (EXU).
- Captures the decoded instruction bundle and GPR operands, then presents them to EXU for one or more cycles.
- Freezes while EXU asserts hold (mul/div or memory stall) and squashes its contents on jump, fence or interrupt flush.
- Inserts NOP bubbles so EXU never acts on a stale or flushed instruction.

Parameters:
- DecInfoWidth, `DECINFO_WIDTH, width of the decoded-info bus.
- NopInst, 32'h00000001, encoding driven on inst_o for a bubble.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hold_i  in  1  stall from pipe_ctrl; stage keeps current contents
- flush_i  in  1  jump, fence or interrupt flush from pipe_ctrl
- inst_valid_i  in  1  IDU instruction valid
- inst_i  in  32  raw instruction
- dec_info_bus_i  in  DecInfoWidth  decoded control bus
- dec_imm_i  in  32  immediate
- dec_pc_i  in  32  instruction PC
- rd_waddr_i  in  5  destination register
- rd_we_i  in  1  destination write enable
- rs1_raddr_i  in  5  source register 1 index
- rs2_raddr_i  in  5  source register 2 index
- reg1_rdata_i  in  32  GPR rs1 data
- reg2_rdata_i  in  32  GPR rs2 data
- wb_we_i  in  1  EXU register write enable (reg_we_o)
- wb_waddr_i  in  5  EXU write address
- wb_wdata_i  in  32  EXU write data
- inst_valid_o, inst_o, dec_info_bus_o, dec_imm_o, dec_pc_o, rd_waddr_o, rd_we_o, reg1_rdata_o, reg2_rdata_o  out  (widths as the inputs)  registered bundle to EXU
- hold_cycles_o  out  8  consecutive cycles the current instruction has been held, saturating

Behaviour:
- Reset values:
  - inst_valid_o=0, inst_o=NopInst.
  - dec_info_bus_o, dec_imm_o, dec_pc_o, rd_waddr_o, rd_we_o, reg1/2_rdata_o all 0.
  - Internal rs1/rs2 index regs 0; hold_cycles_o=0.
- Register update priority per clk edge: flush_i > hold_i > load.
- flush_i=1 (even with hold_i=1):
  - Load a bubble: inst_valid_o=0, inst_o=NopInst, dec_info_bus_o=0, rd_we_o=0.
  - Remaining fields are don't-care but driven 0.
  - hold_cycles_o cleared.
- hold_i=1 and flush_i=0:
  - All outputs retain their values.
  - hold_cycles_o increments by 1, saturating at 8'hFF.
  - Exception: the operand refresh under the optional feature below.
- Load (flush_i=0, hold_i=0):
  - If inst_valid_i=1, capture all inputs and the rs indices; inst_valid_o=1.
  - If inst_valid_i=0, load a bubble exactly as for flush.
  - hold_cycles_o cleared.
- Latency: exactly one cycle from IDU input to EXU output; no internal buffering beyond one entry.
- A bubble must have dec_info_bus_o=0 so every EXU request line is low.
- rd_we_o is forced to 0 whenever inst_valid_o=0.
- Reset asserted mid-hold: all state returns to reset values asynchronously; no partial retention.
- Deasserting hold_i and asserting flush_i in the same cycle: flush wins and the held instruction is discarded.

Optional Feature:
- Macro: IDU_EXU_WB_BYPASS_EN.
- When defined:
  - Load cycle: if wb_we_i=1, wb_waddr_i!=0 and wb_waddr_i==rs1_raddr_i, capture wb_wdata_i instead of reg1_rdata_i. Same rule for rs2.
  - Hold cycle: if wb_we_i=1, wb_waddr_i!=0 and wb_waddr_i equals the stored rs1 index, update reg1_rdata_o with wb_wdata_i. Same rule for rs2.
  - An x0 write never bypasses.
- When undefined:
  - Operands are the raw GPR read data captured at load and stay frozen during hold.
  - wb_* inputs are unused.

Decomposition:
- Shared package: NOP instruction constant, a struct typedef for the IDU→EXU bundle (inst, dec_info, imm, pc, rd, rd_we, operands), and a helper function returning the bubble value.
- One natural sub-module: idu_exu_bypass (combinational match/select per operand). It is instantiated twice and only under IDU_EXU_WB_BYPASS_EN.
- Everything else stays in a single always_ff with async reset.

Test Plan:
- Reset: release rst_n with inputs active → inst_valid_o=0, inst_o=32'h00000001, dec_info_bus_o=0 until the first clk edge.
- Normal flow: inst_i=32'h00a00093, pc=32'h100, valid, no hold/flush → next cycle inst_o=32'h00a00093, dec_pc_o=32'h100, inst_valid_o=1.
- Hold: hold_i=1 for 3 cycles while inputs change → outputs keep the captured instruction, hold_cycles_o reads 1,2,3; release → new instruction loads, hold_cycles_o=0.
- Flush during hold: hold_i=1 and flush_i=1 together → next cycle inst_valid_o=0, rd_we_o=0, dec_info_bus_o=0, inst_o=32'h00000001.
- Bypass (macro on): held instruction with rs1=5, wb_we_i=1, wb_waddr_i=5, wb_wdata_i=32'hDEADBEEF → reg1_rdata_o=32'hDEADBEEF next cycle. Same stimulus with wb_waddr_i=0 → no change.
- Saturation: hold_i=1 for 300 cycles → hold_cycles_o stays 8'hFF from cycle 255 onward.
